// File: rtl/phase_sched_if.sv
// Signal bundle for the phase_sched traffic-phase scheduler: timing strobe,
// requests and overrides in; lights, countdown and phase status out.
interface phase_sched_if;
  logic       tick;
  logic       req_a;
  logic       req_b;
  logic       req_ped;
  logic       emg_a;
  logic       emg_b;
  logic       pause;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic [7:0] remain;
  logic [2:0] phase;
  logic       ped_walk;
  logic       ped_ack;

  modport master (
    output tick, req_a, req_b, req_ped, emg_a, emg_b, pause,
    input  light_a, light_b, remain, phase, ped_walk, ped_ack
  );

  modport slave (
    input  tick, req_a, req_b, req_ped, emg_a, emg_b, pause,
    output light_a, light_b, remain, phase, ped_walk, ped_ack
  );
endinterface

// File: rtl/phase_sched.sv
// Two-road traffic phase scheduler with BCD countdown and emergency hold.
// Define PHASE_SCHED_PED_EN to build in the pedestrian latch and PED_WALK phase.
module phase_sched #(
  parameter int GREEN_S  = 25,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int PED_S    = 15
) (
  input  logic         clk,
  input  logic         rst,
  phase_sched_if.slave bus
);

  localparam logic [7:0] GREEN_BCD  = 8'(((GREEN_S  / 10) * 16) + (GREEN_S  % 10));
  localparam logic [7:0] YELLOW_BCD = 8'(((YELLOW_S / 10) * 16) + (YELLOW_S % 10));
  localparam logic [7:0] ALLRED_BCD = 8'(((ALLRED_S / 10) * 16) + (ALLRED_S % 10));
  localparam logic [7:0] PED_BCD    = 8'(((PED_S    / 10) * 16) + (PED_S    % 10));

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_ALL_RED  = 3'd0,
    S_A_GREEN  = 3'd1,
    S_A_YELLOW = 3'd2,
    S_B_GREEN  = 3'd3,
    S_B_YELLOW = 3'd4,
    S_PED_WALK = 3'd5,
    S_EMG      = 3'd6
  } state_t;

  state_t     r_state, w_nxt_state;
  logic [7:0] r_remain, w_nxt_remain;
  logic       r_last_b, w_nxt_last_b;
  logic       r_emg_b, w_nxt_emg_b;
  logic [2:0] r_light_a, r_light_b, w_light_a, w_light_b;
  logic       w_ped_pend;
  logic       w_dec;
  logic       w_go_b;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_dec  = bus.tick & ~bus.pause;
  // Single requester wins; otherwise alternate against the last served road.
  assign w_go_b = (bus.req_a != bus.req_b) ? bus.req_b : ~r_last_b;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_remain = r_remain;
    w_nxt_last_b = r_last_b;
    w_nxt_emg_b  = r_emg_b;
    if (bus.emg_a | bus.emg_b) begin
      w_nxt_state  = S_EMG;
      w_nxt_remain = 8'h00;
      w_nxt_emg_b  = ~bus.emg_a;
    end else if (r_state == S_EMG) begin
      w_nxt_state  = S_ALL_RED;
      w_nxt_remain = ALLRED_BCD;
    end else if (w_dec) begin
      if (r_remain != 8'h01) begin
        w_nxt_remain = bcd_dec(r_remain);
      end else begin
        unique case (r_state)
          S_ALL_RED: begin
            if (w_ped_pend) begin
              w_nxt_state  = S_PED_WALK;
              w_nxt_remain = PED_BCD;
            end else begin
              w_nxt_state  = w_go_b ? S_B_GREEN : S_A_GREEN;
              w_nxt_remain = GREEN_BCD;
              w_nxt_last_b = w_go_b;
            end
          end
          S_A_GREEN: begin
            // No one waiting on the other side: hold green for another period.
            if (bus.req_b | w_ped_pend) begin
              w_nxt_state  = S_A_YELLOW;
              w_nxt_remain = YELLOW_BCD;
            end else begin
              w_nxt_remain = GREEN_BCD;
            end
          end
          S_B_GREEN: begin
            if (bus.req_a | w_ped_pend) begin
              w_nxt_state  = S_B_YELLOW;
              w_nxt_remain = YELLOW_BCD;
            end else begin
              w_nxt_remain = GREEN_BCD;
            end
          end
          default: begin
            w_nxt_state  = S_ALL_RED;
            w_nxt_remain = ALLRED_BCD;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_light_a = L_RED;
    w_light_b = L_RED;
    case (w_nxt_state)
      S_A_GREEN:  w_light_a = L_GRN;
      S_A_YELLOW: w_light_a = L_YEL;
      S_B_GREEN:  w_light_b = L_GRN;
      S_B_YELLOW: w_light_b = L_YEL;
      S_EMG: begin
        if (w_nxt_emg_b) w_light_b = L_GRN;
        else             w_light_a = L_GRN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_ALL_RED;
      r_remain  <= ALLRED_BCD;
      r_last_b  <= 1'b1;
      r_emg_b   <= 1'b0;
      r_light_a <= L_RED;
      r_light_b <= L_RED;
    end else begin
      r_state   <= w_nxt_state;
      r_remain  <= w_nxt_remain;
      r_last_b  <= w_nxt_last_b;
      r_emg_b   <= w_nxt_emg_b;
      r_light_a <= w_light_a;
      r_light_b <= w_light_b;
    end
  end

`ifdef PHASE_SCHED_PED_EN
  logic r_ped, r_ped_walk;

  assign w_ped_pend = r_ped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped      <= 1'b0;
      r_ped_walk <= 1'b0;
    end else begin
      r_ped_walk <= (w_nxt_state == S_PED_WALK);
      if (w_nxt_state == S_PED_WALK && r_state != S_PED_WALK) r_ped <= 1'b0;
      else if (bus.req_ped)                                   r_ped <= 1'b1;
    end
  end

  assign bus.ped_walk = r_ped_walk;
  assign bus.ped_ack  = r_ped;
`else
  logic w_unused_ped;

  assign w_ped_pend   = 1'b0;
  assign w_unused_ped = bus.req_ped;
  assign bus.ped_walk = 1'b0;
  assign bus.ped_ack  = 1'b0;
`endif

  assign bus.phase   = r_state;
  assign bus.remain  = r_remain;
  assign bus.light_a = r_light_a;
  assign bus.light_b = r_light_b;

endmodule
